ball_engine: RTL
================

// Module: ball_engine
// PURPOSE
//  Parametrised successor to the fixed 32x32-mask ball painter: owns ball position and
//  direction, moves it one step per frame tick with wall bounce, and paints any radius
//  with a pipelined distance-squared disc test instead of a mask ROM. It sits between
//  the XGA timing generator (h_pos/v_pos) and the RGB output stage.
// PARAMETERS
//  width        1024        active pixels per line
//  height       768         active lines per frame
//  color_depth  8           bits per colour channel; rgb is 3*color_depth bits
//  ball_radius  16          disc radius in pixels, >=1
//  speed        2           pixels moved per axis per move tick, >=1
//  x_start      width/2     centre x after reset
//  y_start      height/2    centre y after reset
//  bkg_color    24'h000000  background colour, 3*color_depth bits
//  ball_color   24'hFFFFFF  ball colour, 3*color_depth bits
// PORTS
//  clk        in   1                  pixel clock
//  reset      in   1                  asynchronous, active-low reset
//  move       in   1                  frame tick, 1-cycle pulse, issued in vertical blank
//  enable     in   1                  1 = move ticks update position; 0 = ball frozen
//  pix_valid  in   1                  h_pos/v_pos hold an active pixel
//  h_pos      in   log2(width)        current scan x
//  v_pos      in   log2(height)       current scan y
//  rgb        out  3*color_depth      pixel colour, 2 cycles after h_pos/v_pos
//  rgb_valid  out  1                  pix_valid delayed 2 cycles
//  x_pixel    out  log2(width)        registered ball centre x
//  y_pixel    out  log2(height)       registered ball centre y
//  bounce     out  1                  1-cycle pulse on the tick that reflects either axis
// BEHAVIOUR
//  - Reset: x_pixel=x_start, y_pixel=y_start, direction=SE (+x,+y), bounce=0, rgb=bkg_color,
//    rgb_valid=0. All pipeline registers clear.
//  - Limits: XMAX=width-1-ball_radius, XMIN=ball_radius; YMAX and YMIN are defined the same way.
//  - Direction FSM: the states are NE, NW, SE, SW. It updates only when move=1 and enable=1.
//  - On each axis with +dir: if pos+speed>=MAX, set pos=MAX and flip that axis. Otherwise
//    set pos=pos+speed. -dir mirrors this: if pos<=MIN+speed, set pos=MIN and flip.
//  - Corner case: both axes can flip on the same tick, e.g. SE->NW. bounce still pulses only once.
//  - bounce asserts the cycle after a tick that flips an axis. It is 0 otherwise.
//  - move while enable=0: no change, bounce stays 0. A move held high repeats the update
//    every cycle; the caller guarantees a single-cycle pulse.
//  - Render stage 1 registers signed dx=h_pos-x_pixel and dy=v_pos-y_pixel, plus pix_valid.
//    Stage 1 samples the centre present in that same cycle.
//  - Render stage 2 registers in_disc=(dx*dx+dy*dy <= r*r) and valid.
//  - rgb = in_disc && valid ? ball_color : bkg_color.
//  - Widths: dx/dy are log2(width)+1 signed. Squares and their sum are 2*log2(width)+2
//    unsigned, so no overflow. r*r is a localparam.
//  - pix_valid=0 forces rgb=bkg_color two cycles later, regardless of position.
//  - Reset asserted mid-frame clears position, direction and pipeline immediately.
//    The first rgb after release is bkg_color.
//  - Elaboration check: width and height must each exceed 2*ball_radius+2*speed.
//    If not, $error.
// STRUCTURE
//  - Package ball_pkg: dir_t enum {NE,NW,SE,SW} and axis-flip helper functions.
//    log2 comes from const_funcs.h.
//  - Sub-module ball_disc_test: the 2-stage dx/dy -> in_disc pipeline, parametrised on
//    coordinate width and ball_radius.
//  - The top holds the position/direction FSM and the colour mux.
// TESTING  (width=64 height=48 radius=4 speed=2 start=(20,10))
//  - Reset release -> x_pixel=20, y_pixel=10, bounce=0, rgb=bkg, rgb_valid=0.
//  - One move, enable=1 -> (22,12), still SE, bounce=0.
//  - enable=0 with 3 moves -> position holds (20,10).
//  - Right wall, start x=57 dir SE, move -> x=59 (XMAX), dir SW, bounce=1 for one cycle.
//  - Corner, centre (57,41) SE, move -> (59,43), dir NW, exactly one bounce pulse.
//  - Render at centre (20,10): pixel (20,14) -> ball_color 2 cycles later;
//    (20,15) -> bkg; (17,7) -> bkg (18>16).
//  - Reset pulse while ball at (40,30) NW with pix_valid streaming -> (20,10) SE;
//    rgb=bkg until 2 cycles after release.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared types and helpers for the bouncing-ball painter.
package ball_pkg;

  // Direction of travel: N/S is the y axis (S = +y), E/W is the x axis (E = +x).
  typedef enum logic [1:0] {
    NE = 2'd0,
    NW = 2'd1,
    SE = 2'd2,
    SW = 2'd3
  } dir_t;

  function automatic logic dir_is_east(dir_t d);
    return (d == NE) || (d == SE);
  endfunction

  function automatic logic dir_is_south(dir_t d);
    return (d == SE) || (d == SW);
  endfunction

  function automatic dir_t dir_make(logic east, logic south);
    dir_t d;
    case ({south, east})
      2'b00:   d = NW;
      2'b01:   d = NE;
      2'b10:   d = SW;
      default: d = SE;
    endcase
    return d;
  endfunction

  // Reflect the axes whose flip flag is set; both may flip on a corner hit.
  function automatic dir_t dir_flip(dir_t d, logic flip_x, logic flip_y);
    return dir_make(dir_is_east(d) ^ flip_x, dir_is_south(d) ^ flip_y);
  endfunction

endpackage

// File: rtl/ball_disc_test.sv
// Two-stage pipeline: pixel offset from the ball centre, then the
// distance-squared against radius-squared test.
module ball_disc_test #(
  parameter int coord_w     = 10,
  parameter int ball_radius = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               pix_valid_i,
  input  logic [coord_w-1:0] h_pos_i,
  input  logic [coord_w-1:0] v_pos_i,
  input  logic [coord_w-1:0] x_c_i,
  input  logic [coord_w-1:0] y_c_i,
  output logic               in_disc_o,
  output logic               valid_o
);

  // Squares of a (coord_w+1)-bit signed value and their sum fit here without overflow.
  localparam int SQ_W = 2 * coord_w + 2;
  localparam logic [SQ_W-1:0] R_SQ = SQ_W'(ball_radius * ball_radius);

  logic signed [coord_w:0] dx_d, dy_d, dx_q, dy_q;
  logic signed [SQ_W-1:0]  dx_w, dy_w;
  logic [SQ_W-1:0]         dist_sq;
  logic                    v1_q, v2_q, in_disc_q;

  assign dx_d = $signed({1'b0, h_pos_i}) - $signed({1'b0, x_c_i});
  assign dy_d = $signed({1'b0, v_pos_i}) - $signed({1'b0, y_c_i});

  assign dx_w    = {{(SQ_W-coord_w-1){dx_q[coord_w]}}, dx_q};
  assign dy_w    = {{(SQ_W-coord_w-1){dy_q[coord_w]}}, dy_q};
  assign dist_sq = unsigned'(dx_w * dx_w) + unsigned'(dy_w * dy_w);

  // Stage 1 latches the signed offsets, stage 2 the disc membership.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dx_q      <= '0;
      dy_q      <= '0;
      v1_q      <= 1'b0;
      in_disc_q <= 1'b0;
      v2_q      <= 1'b0;
    end else begin
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      v1_q      <= pix_valid_i;
      in_disc_q <= (dist_sq <= R_SQ);
      v2_q      <= v1_q;
    end
  end

  assign in_disc_o = in_disc_q;
  assign valid_o   = v2_q;

endmodule

// File: rtl/ball_engine.sv
// Ball position/direction controller with wall bounce, plus disc renderer
// and colour mux sitting between the scan timing and the RGB output stage.
//
//   state | meaning
//   NE    | moving +x, -y
//   NW    | moving -x, -y
//   SE    | moving +x, +y (reset)
//   SW    | moving -x, +y
module ball_engine
  import ball_pkg::*;
#(
  parameter int width       = 1024,
  parameter int height      = 768,
  parameter int color_depth = 8,
  parameter int ball_radius = 16,
  parameter int speed       = 2,
  parameter int x_start     = width / 2,
  parameter int y_start     = height / 2,
  parameter logic [3*color_depth-1:0] bkg_color  = '0,
  parameter logic [3*color_depth-1:0] ball_color = '1,
  localparam int XW = $clog2(width),
  localparam int YW = $clog2(height)
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     move_i,
  input  logic                     enable_i,
  input  logic                     pix_valid_i,
  input  logic [XW-1:0]            h_pos_i,
  input  logic [YW-1:0]            v_pos_i,
  output logic [3*color_depth-1:0] rgb_o,
  output logic                     rgb_valid_o,
  output logic [XW-1:0]            x_pixel_o,
  output logic [YW-1:0]            y_pixel_o,
  output logic                     bounce_o
);

  localparam int CW = (XW > YW) ? XW : YW;

  // Limit compares run one bit wider so pos+speed never wraps.
  localparam logic [XW:0] X_HI  = (XW+1)'(width - 1 - ball_radius);
  localparam logic [XW:0] X_LO  = (XW+1)'(ball_radius + speed);
  localparam logic [XW:0] X_SPD = (XW+1)'(speed);
  localparam logic [YW:0] Y_HI  = (YW+1)'(height - 1 - ball_radius);
  localparam logic [YW:0] Y_LO  = (YW+1)'(ball_radius + speed);
  localparam logic [YW:0] Y_SPD = (YW+1)'(speed);

  if ((width <= 2*ball_radius + 2*speed) || (height <= 2*ball_radius + 2*speed)) begin : g_bad_geometry
    $error("ball_engine: width and height must exceed 2*ball_radius+2*speed");
  end

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  dir_t          dir_q;
  logic          bounce_q, flip_x, flip_y, tick;
  logic          in_disc, disc_valid;

  assign tick = move_i & enable_i;

  // Candidate next position and per-axis reflection for the current direction.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    flip_x = 1'b0;
    flip_y = 1'b0;
    if (dir_is_east(dir_q)) begin
      if ({1'b0, x_q} + X_SPD >= X_HI) begin
        x_d    = X_HI[XW-1:0];
        flip_x = 1'b1;
      end else begin
        x_d = x_q + X_SPD[XW-1:0];
      end
    end else if ({1'b0, x_q} <= X_LO) begin
      x_d    = XW'(ball_radius);
      flip_x = 1'b1;
    end else begin
      x_d = x_q - X_SPD[XW-1:0];
    end
    if (dir_is_south(dir_q)) begin
      if ({1'b0, y_q} + Y_SPD >= Y_HI) begin
        y_d    = Y_HI[YW-1:0];
        flip_y = 1'b1;
      end else begin
        y_d = y_q + Y_SPD[YW-1:0];
      end
    end else if ({1'b0, y_q} <= Y_LO) begin
      y_d    = YW'(ball_radius);
      flip_y = 1'b1;
    end else begin
      y_d = y_q - Y_SPD[YW-1:0];
    end
  end

  // Position/direction FSM; bounce is one pulse even when both axes reflect.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x_q      <= XW'(x_start);
      y_q      <= YW'(y_start);
      dir_q    <= SE;
      bounce_q <= 1'b0;
    end else begin
      bounce_q <= tick & (flip_x | flip_y);
      if (tick) begin
        x_q   <= x_d;
        y_q   <= y_d;
        dir_q <= dir_flip(dir_q, flip_x, flip_y);
      end
    end
  end

  ball_disc_test #(
    .coord_w     (CW),
    .ball_radius (ball_radius)
  ) u_disc (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .pix_valid_i (pix_valid_i),
    .h_pos_i     (CW'(h_pos_i)),
    .v_pos_i     (CW'(v_pos_i)),
    .x_c_i       (CW'(x_q)),
    .y_c_i       (CW'(y_q)),
    .in_disc_o   (in_disc),
    .valid_o     (disc_valid)
  );

  assign rgb_o       = (in_disc && disc_valid) ? ball_color : bkg_color;
  assign rgb_valid_o = disc_valid;
  assign x_pixel_o   = x_q;
  assign y_pixel_o   = y_q;
  assign bounce_o    = bounce_q;

endmodule
